// File: rtl/pong_pkg.sv
// Shared constants for the VGA pong driver: screen size, coordinate width,
// default paddle geometry and movement rate.
package pong_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int COORD_W   = 10;

    localparam int DEFAULT_TICK_DIV   = 250000;
    localparam int DEFAULT_STEP       = 4;
    localparam int DEFAULT_H_LEFT     = 20;
    localparam int DEFAULT_PADDLE_W   = 10;
    localparam int DEFAULT_PADDLE_H   = 80;
    localparam int DEFAULT_V_TOP      = 0;
    localparam int DEFAULT_V_BOTTOM   = V_VISIBLE - 1;
    localparam int DEFAULT_RESET_VPOS = 200;

    // Lowest legal top row for a paddle of height h, so that its bottom row sits on v_bottom.
    function automatic int max_top_row(input int v_bottom, input int h);
        return v_bottom - h + 1;
    endfunction

endpackage

// File: rtl/paddle_position_if.sv
// Paddle control/position bundle: move requests in, bounding box out.
// The slave side is the paddle_position block; the master side drives the
// buttons and consumes the bounding box.
interface paddle_position_if;
    import pong_pkg::*;

    logic               moveUp;
    logic               moveDown;
    logic [COORD_W-1:0] Hmin;
    logic [COORD_W-1:0] Hmax;
    logic [COORD_W-1:0] Vmin;
    logic [COORD_W-1:0] Vmax;

    modport master (
        output moveUp,
        output moveDown,
        input  Hmin,
        input  Hmax,
        input  Vmin,
        input  Vmax
    );

    modport slave (
        input  moveUp,
        input  moveDown,
        output Hmin,
        output Hmax,
        output Vmin,
        output Vmax
    );

endinterface

// File: rtl/paddle_position_move_tick_gen.sv
// Movement prescaler: free-running 0..TICK_DIV-1 counter whose tick output
// is high exactly in the cycle where the count equals TICK_DIV-1.
module move_tick_gen #(
    parameter int TICK_DIV = 250000
) (
    input  logic CLK_100MHz,
    input  logic Reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;
    logic             tick_r;

    // Count cycles; tick is registered one step ahead so it coincides with count==TICK_DIV-1.
    always_ff @(posedge CLK_100MHz) begin
        if (Reset) begin
            count_r <= {CNT_W{1'b0}};
            tick_r  <= 1'b0;
        end else if (count_r == CNT_LAST) begin
            count_r <= {CNT_W{1'b0}};
            tick_r  <= 1'b0;
        end else begin
            count_r <= count_r + CNT_ONE;
            tick_r  <= ((count_r + CNT_ONE) == CNT_LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/paddle_position.sv
// Bounding box of one Pong paddle. The paddle moves vertically by STEP rows
// per movement tick while exactly one of moveUp/moveDown is held, clamped to
// [V_TOP, V_BOTTOM]. Optional macro PADDLE_POSITION_INPUT_SYNC_EN inserts a
// two-flop synchronizer on the button inputs (asynchronous push-buttons).
module paddle_position
    import pong_pkg::*;
#(
    parameter int TICK_DIV   = DEFAULT_TICK_DIV,
    parameter int STEP       = DEFAULT_STEP,
    parameter int H_LEFT     = DEFAULT_H_LEFT,
    parameter int PADDLE_W   = DEFAULT_PADDLE_W,
    parameter int PADDLE_H   = DEFAULT_PADDLE_H,
    parameter int V_TOP      = DEFAULT_V_TOP,
    parameter int V_BOTTOM   = DEFAULT_V_BOTTOM,
    parameter int RESET_VPOS = DEFAULT_RESET_VPOS
) (
    input  logic              CLK_100MHz,
    input  logic              Reset,
    paddle_position_if.slave  bus
);

    // Clamp arithmetic is one bit wider than a coordinate so nothing wraps.
    localparam logic [COORD_W:0]   TOP_LIM   = (COORD_W+1)'(V_TOP);
    localparam logic [COORD_W:0]   BOT_LIM   = (COORD_W+1)'(max_top_row(V_BOTTOM, PADDLE_H));
    localparam logic [COORD_W:0]   STEP_W    = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0]   UP_OK     = (COORD_W+1)'(V_TOP + STEP);
    localparam logic [COORD_W-1:0] H_MIN_C   = COORD_W'(H_LEFT);
    localparam logic [COORD_W-1:0] H_MAX_C   = COORD_W'(H_LEFT + PADDLE_W - 1);
    localparam logic [COORD_W-1:0] V_RST_C   = COORD_W'(RESET_VPOS);
    localparam logic [COORD_W-1:0] V_RST_MAX = COORD_W'(RESET_VPOS + PADDLE_H - 1);
    localparam logic [COORD_W-1:0] H_OFF     = COORD_W'(PADDLE_H - 1);

    generate
        if (TICK_DIV < 2) begin : g_bad_div
            $error("paddle_position: TICK_DIV must be at least 2");
        end
        if (PADDLE_H > V_BOTTOM - V_TOP + 1) begin : g_bad_height
            $error("paddle_position: PADDLE_H does not fit between V_TOP and V_BOTTOM");
        end
        if ((RESET_VPOS < V_TOP) || (RESET_VPOS > V_BOTTOM - PADDLE_H + 1)) begin : g_bad_reset
            $error("paddle_position: RESET_VPOS places the paddle outside the field");
        end
    endgenerate

    logic               up_s;
    logic               down_s;
    logic               tick_s;
    logic [COORD_W:0]   vpos_ext_s;
    logic [COORD_W-1:0] next_vpos_s;
    logic [COORD_W-1:0] hmin_r;
    logic [COORD_W-1:0] hmax_r;
    logic [COORD_W-1:0] vmin_r;
    logic [COORD_W-1:0] vmax_r;

`ifdef PADDLE_POSITION_INPUT_SYNC_EN
    logic [1:0] up_sync_r;
    logic [1:0] down_sync_r;

    // Two-flop synchronizers bring asynchronous button levels into the clock domain.
    always_ff @(posedge CLK_100MHz) begin
        if (Reset) begin
            up_sync_r   <= 2'b00;
            down_sync_r <= 2'b00;
        end else begin
            up_sync_r   <= {up_sync_r[0], bus.moveUp};
            down_sync_r <= {down_sync_r[0], bus.moveDown};
        end
    end

    assign up_s   = up_sync_r[1];
    assign down_s = down_sync_r[1];
`else
    assign up_s   = bus.moveUp;
    assign down_s = bus.moveDown;
`endif

    move_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .CLK_100MHz (CLK_100MHz),
        .Reset      (Reset),
        .tick       (tick_s)
    );

    assign vpos_ext_s = {1'b0, vmin_r};

    // Next top row: buttons only matter on a tick, conflicting or idle buttons hold.
    always_comb begin
        next_vpos_s = vmin_r;
        if (tick_s) begin
            case ({up_s, down_s})
                2'b10: begin
                    if (vpos_ext_s >= UP_OK) begin
                        next_vpos_s = COORD_W'(vpos_ext_s - STEP_W);
                    end else begin
                        next_vpos_s = COORD_W'(TOP_LIM);
                    end
                end
                2'b01: begin
                    if ((vpos_ext_s + STEP_W) <= BOT_LIM) begin
                        next_vpos_s = COORD_W'(vpos_ext_s + STEP_W);
                    end else begin
                        next_vpos_s = COORD_W'(BOT_LIM);
                    end
                end
                default: begin
                    next_vpos_s = vmin_r;
                end
            endcase
        end else begin
            next_vpos_s = vmin_r;
        end
    end

    // Registered bounding box; Vmin/Vmax move together on the accepting tick edge.
    always_ff @(posedge CLK_100MHz) begin
        if (Reset) begin
            hmin_r <= H_MIN_C;
            hmax_r <= H_MAX_C;
            vmin_r <= V_RST_C;
            vmax_r <= V_RST_MAX;
        end else begin
            hmin_r <= H_MIN_C;
            hmax_r <= H_MAX_C;
            vmin_r <= next_vpos_s;
            vmax_r <= next_vpos_s + H_OFF;
        end
    end

    assign bus.Hmin = hmin_r;
    assign bus.Hmax = hmax_r;
    assign bus.Vmin = vmin_r;
    assign bus.Vmax = vmax_r;

endmodule

// File: tb/tb_paddle_position.sv
// Self-checking bench for paddle_position with TICK_DIV=4, STEP=4. A
// reference model tracks the paddle row from edge counts since reset.
// Honours PADDLE_POSITION_INPUT_SYNC_EN (two extra cycles of input latency).
module tb_paddle_position;

    localparam int TB_DIV   = 4;
    localparam int TB_STEP  = 4;
    localparam int TB_H     = 80;
    localparam int TB_LOW   = 0;
    localparam int TB_HIGH  = 479 - TB_H + 1;
`ifdef PADDLE_POSITION_INPUT_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    // Model state: row, edges since reset, and the button history seen at past edges.
    int m_vpos;
    int m_k;
    int m_up1, m_up2, m_dn1, m_dn2;

    paddle_position_if bus ();

    paddle_position #(
        .TICK_DIV (TB_DIV),
        .STEP     (TB_STEP)
    ) dut (
        .CLK_100MHz (clk),
        .Reset      (rst),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge(input int r, input int u, input int d);
        int eu;
        int ed;
        if (r != 0) begin
            m_vpos = 200;
            m_k    = 0;
            m_up1 = 0; m_up2 = 0; m_dn1 = 0; m_dn2 = 0;
        end else begin
            m_k++;
            eu = SYNC ? m_up2 : u;
            ed = SYNC ? m_dn2 : d;
            if (m_k % TB_DIV == 0) begin
                if (eu != 0 && ed == 0) m_vpos = (m_vpos - TB_STEP < TB_LOW) ? TB_LOW : m_vpos - TB_STEP;
                else if (ed != 0 && eu == 0) m_vpos = (m_vpos + TB_STEP > TB_HIGH) ? TB_HIGH : m_vpos + TB_STEP;
            end
            m_up2 = m_up1; m_up1 = u;
            m_dn2 = m_dn1; m_dn1 = d;
        end
    endtask

    task automatic step(input logic r, input logic u, input logic d);
        rst = r;
        bus.moveUp = u;
        bus.moveDown = d;
        @(posedge clk);
        model_edge(int'(r), int'(u), int'(d));
        @(negedge clk);
    endtask

    task automatic test_reset();
        int exp;
        step(1'b1, 1'b0, 1'b0);
        tests++; if (bus.Hmin !== 10'd20)  begin fails++; $display("FAIL reset_hmin: got %0d expected 20", bus.Hmin); end
        tests++; if (bus.Hmax !== 10'd29)  begin fails++; $display("FAIL reset_hmax: got %0d expected 29", bus.Hmax); end
        tests++; if (bus.Vmin !== 10'd200) begin fails++; $display("FAIL reset_vmin: got %0d expected 200", bus.Vmin); end
        tests++; if (bus.Vmax !== 10'd279) begin fails++; $display("FAIL reset_vmax: got %0d expected 279", bus.Vmax); end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        tests++; if (bus.Vmin !== 10'd200) begin fails++; $display("FAIL pre_tick_hold: got %0d expected 200", bus.Vmin); end
        step(1'b0, 1'b1, 1'b0);
        exp = SYNC ? 200 : 196;
        tests++; if (int'(bus.Vmin) != exp || exp != m_vpos) begin fails++; $display("FAIL first_tick: got %0d expected %0d (model %0d)", bus.Vmin, exp, m_vpos); end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        exp = SYNC ? 196 : 192;
        tests++; if (int'(bus.Vmin) != exp || exp != m_vpos) begin fails++; $display("FAIL second_tick: got %0d expected %0d (model %0d)", bus.Vmin, exp, m_vpos); end
    endtask

    task automatic test_move_up_down();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);
        tests++; if (bus.Vmin !== 10'd160 || bus.Vmax !== 10'd239) begin fails++; $display("FAIL up_40: got %0d/%0d expected 160/239", bus.Vmin, bus.Vmax); end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
        tests++; if (bus.Vmin !== 10'd160 || m_vpos != 160) begin fails++; $display("FAIL up_release_hold: got %0d expected 160", bus.Vmin); end
        for (int i = 0; i < 80; i++) step(1'b0, 1'b0, 1'b1);
        tests++; if (bus.Vmin !== 10'd240 || bus.Vmax !== 10'd319) begin fails++; $display("FAIL down_80: got %0d/%0d expected 240/319", bus.Vmin, bus.Vmax); end
    endtask

    task automatic test_saturate();
        int bad;
        bad = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (bus.Vmax < bus.Vmin || bus.Vmin > 10'd400) bad++;
        end
        tests++; if (bus.Vmin !== 10'd0 || bus.Vmax !== 10'd79) begin fails++; $display("FAIL top_clamp: got %0d/%0d expected 0/79", bus.Vmin, bus.Vmax); end
        for (int i = 0; i < 800; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (bus.Vmax > 10'd479 || bus.Vmax < bus.Vmin) bad++;
        end
        tests++; if (bus.Vmin !== 10'd400 || bus.Vmax !== 10'd479) begin fails++; $display("FAIL bottom_clamp: got %0d/%0d expected 400/479", bus.Vmin, bus.Vmax); end
        tests++; if (bad != 0) begin fails++; $display("FAIL clamp_invariant: got %0d violations expected 0", bad); end
    endtask

    task automatic test_conflict_and_pulse();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1);
        tests++; if (bus.Vmin !== 10'd200) begin fails++; $display("FAIL both_pressed: got %0d expected 200", bus.Vmin); end
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b0);
        tests++; if (bus.Vmin !== 10'd200 || m_vpos != 200) begin fails++; $display("FAIL off_tick_pulse: got %0d expected 200", bus.Vmin); end
    endtask

    task automatic test_reset_in_tick();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        tests++; if (bus.Vmin !== 10'd200) begin fails++; $display("FAIL reset_beats_tick: got %0d expected 200", bus.Vmin); end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        tests++; if (bus.Vmin !== 10'd200) begin fails++; $display("FAIL counter_restart: got %0d expected 200", bus.Vmin); end
        step(1'b0, 1'b1, 1'b0);
        tests++; if (bus.Vmin !== 10'd196 || m_vpos != 196) begin fails++; $display("FAIL restart_tick: got %0d expected 196", bus.Vmin); end
    endtask

    task automatic test_random();
        logic u, d, r;
        int   len;
        int   nerr;
        nerr = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int seg = 0; seg < 120; seg++) begin
            u   = 1'($urandom_range(0, 1));
            d   = 1'($urandom_range(0, 1));
            r   = ($urandom_range(0, 29) == 0);
            len = int'($urandom_range(1, 20));
            for (int c = 0; c < len; c++) begin
                step((c == 0) ? r : 1'b0, u, d);
                tests++;
                if (int'(bus.Vmin) != m_vpos || int'(bus.Vmax) != m_vpos + TB_H - 1 ||
                    bus.Hmin !== 10'd20 || bus.Hmax !== 10'd29) begin
                    fails++;
                    if (nerr < 10) $display("FAIL random_seg%0d: got Vmin=%0d Vmax=%0d expected %0d/%0d", seg, bus.Vmin, bus.Vmax, m_vpos, m_vpos + TB_H - 1);
                    nerr++;
                end
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.moveUp = 1'b0;
        bus.moveDown = 1'b0;
        m_vpos = 200; m_k = 0;
        m_up1 = 0; m_up2 = 0; m_dn1 = 0; m_dn2 = 0;
        @(negedge clk);
        test_reset();
        test_move_up_down();
        test_saturate();
        test_conflict_and_pulse();
        test_reset_in_tick();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
